// File: rtl/link_list_ram_rr.sv
// Link-list next-pointer store: per-channel write FIFOs drain round-robin into one memory
// write port; reads are arbitrated round-robin behind a priority drop channel, with write forwarding.
module link_list_ram_rr #(
  parameter int ADDR_LENTH  = 12,
  parameter int NCH         = 4,
  parameter int WFIFO_DEPTH = 2
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic [NCH*ADDR_LENTH-1:0] iWriteLdata,
  input  logic [NCH*ADDR_LENTH-1:0] iWriteLaddr,
  input  logic [NCH-1:0]            iWriteLaddrVld,
  output logic [NCH-1:0]            oWrOvf,
  input  logic [NCH*ADDR_LENTH-1:0] iLaddr,
  input  logic [NCH-1:0]            iLNxtAddrReq,
  output logic [NCH*ADDR_LENTH-1:0] oLdata,
  output logic [NCH-1:0]            oLdataVld,
  input  logic [ADDR_LENTH-1:0]     iDropAddr,
  input  logic                      iDropAddrVld,
  output logic [ADDR_LENTH-1:0]     oDropData,
  output logic                      oDropDataVld
);
  localparam int CH_W = $clog2(NCH);
  localparam int PW   = $clog2(WFIFO_DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(WFIFO_DEPTH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NCH-1);

  typedef logic [ADDR_LENTH-1:0] word_t;

  // Returns {found, index} of the first set request at or after start, wrapping at NCH.
  function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] req, input logic [CH_W-1:0] start);
    logic [CH_W:0] res;
    logic [CH_W:0] idx;
    res = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      idx = {1'b0, start} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NCH)) idx = idx - (CH_W+1)'(NCH);
      if (req[idx[CH_W-1:0]]) res = {1'b1, idx[CH_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] idx);
    return (idx == LAST_CH) ? '0 : idx + CH_W'(1);
  endfunction

  word_t           mem [2**ADDR_LENTH];
  word_t           fifo_data [NCH][WFIFO_DEPTH];
  word_t           fifo_addr [NCH][WFIFO_DEPTH];
  logic [PW-1:0]   fifo_wp [NCH];
  logic [PW-1:0]   fifo_rp [NCH];
  logic [PW:0]     fifo_cnt [NCH];
  logic [NCH-1:0]  fifo_full, fifo_nempty, push, pop, ovf_set;

  logic [CH_W:0]   wr_pick, rd_pick;
  logic            wr_en, rd_drop, rd_ch_vld;
  logic [CH_W-1:0] wr_ch, rd_ch, w_ptr, r_ptr;
  word_t           wr_addr, wr_data, rd_addr;
  logic [NCH-1:0]  rd_elig;

  logic            tag_ch_vld_p1, tag_drop_p1;
  logic [CH_W-1:0] tag_ch_p1;
  word_t           rd_data_p1;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      fifo_full[k]   = (fifo_cnt[k] == FULL_CNT);
      fifo_nempty[k] = (fifo_cnt[k] != '0);
    end
  end

  always_comb begin
    wr_pick = rr_pick(fifo_nempty, w_ptr);
    wr_en   = wr_pick[CH_W];
    wr_ch   = wr_pick[CH_W-1:0];
    wr_addr = fifo_addr[wr_ch][fifo_rp[wr_ch]];
    wr_data = fifo_data[wr_ch][fifo_rp[wr_ch]];
  end

  // A full FIFO still accepts a push when it is popped on the same edge.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      pop[k]     = wr_en && (wr_ch == CH_W'(k));
      push[k]    = iWriteLaddrVld[k] && (!fifo_full[k] || pop[k]);
      ovf_set[k] = iWriteLaddrVld[k] && fifo_full[k] && !pop[k];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int k = 0; k < NCH; k++) begin
        fifo_wp[k]  <= '0;
        fifo_rp[k]  <= '0;
        fifo_cnt[k] <= '0;
      end
      oWrOvf <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (push[k]) fifo_wp[k] <= fifo_wp[k] + PW'(1);
        if (pop[k])  fifo_rp[k] <= fifo_rp[k] + PW'(1);
        case ({push[k], pop[k]})
          2'b10:   fifo_cnt[k] <= fifo_cnt[k] + (PW+1)'(1);
          2'b01:   fifo_cnt[k] <= fifo_cnt[k] - (PW+1)'(1);
          default: ;
        endcase
      end
      oWrOvf <= oWrOvf | ovf_set;
    end
  end

  always_ff @(posedge iClk) begin
    for (int k = 0; k < NCH; k++) begin
      if (push[k]) begin
        fifo_data[k][fifo_wp[k]] <= iWriteLdata[k*ADDR_LENTH +: ADDR_LENTH];
        fifo_addr[k][fifo_wp[k]] <= iWriteLaddr[k*ADDR_LENTH +: ADDR_LENTH];
      end
    end
  end

  always_comb begin
    rd_elig   = iLNxtAddrReq & ~oLdataVld;
    rd_pick   = rr_pick(rd_elig, r_ptr);
    rd_drop   = iDropAddrVld;
    rd_ch_vld = !iDropAddrVld && rd_pick[CH_W];
    rd_ch     = rd_pick[CH_W-1:0];
    rd_addr   = rd_drop ? iDropAddr : iLaddr[rd_ch*ADDR_LENTH +: ADDR_LENTH];
  end

  // p0 -> p1: arbitration pointers and the result-routing tag
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      w_ptr         <= '0;
      r_ptr         <= '0;
      tag_ch_vld_p1 <= 1'b0;
      tag_drop_p1   <= 1'b0;
      tag_ch_p1     <= '0;
    end else begin
      if (wr_en)     w_ptr <= rr_next(wr_ch);
      if (rd_ch_vld) r_ptr <= rr_next(rd_ch);
      tag_ch_vld_p1 <= rd_ch_vld;
      tag_drop_p1   <= rd_drop;
      tag_ch_p1     <= rd_ch;
    end
  end

  always_ff @(posedge iClk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_drop || rd_ch_vld)
      rd_data_p1 <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

  // p1: steer the read word onto exactly one output strobe
  always_comb begin
    oLdata    = '0;
    oLdataVld = '0;
    for (int k = 0; k < NCH; k++) begin
      if (tag_ch_vld_p1 && tag_ch_p1 == CH_W'(k)) begin
        oLdataVld[k]                        = 1'b1;
        oLdata[k*ADDR_LENTH +: ADDR_LENTH] = rd_data_p1;
      end
    end
    oDropDataVld = tag_drop_p1;
    oDropData    = tag_drop_p1 ? rd_data_p1 : '0;
  end
endmodule

// File: doc/link_list_ram_rr.md
# link_list_ram_rr

Parametrised link-list next-pointer store for the switch buffer manager. It accepts next-pointer writes from NCH unpack channels through per-channel FIFOs, and serves next-pointer reads for NCH packet-read channels plus one priority drop channel. Both the write side and the read side use round-robin arbitration, and the block forwards same-cycle write data to reads. It sits between the unpack/packet-read engines and the free-address recycler, in place of the fixed 4-channel link-list store.

## Interface
Parameters
- ADDR_LENTH, 12: block-address width; memory is 2**ADDR_LENTH words of ADDR_LENTH bits.
- NCH, 4: number of write channels and number of read channels (2..8).
- WFIFO_DEPTH, 2: per-channel write FIFO depth (power of 2, ≥2).

Ports
- iClk, in, 1: single clock.
- iRst_n, in, 1: reset, asynchronous, active-low.
- iWriteLdata, in, NCH*ADDR_LENTH: next-pointer value; channel k occupies slice [k*ADDR_LENTH +: ADDR_LENTH].
- iWriteLaddr, in, NCH*ADDR_LENTH: address written.
- iWriteLaddrVld, in, NCH: push strobe per channel.
- oWrOvf, out, NCH: sticky overflow flag per channel.
- iLaddr, in, NCH*ADDR_LENTH: read address per channel.
- iLNxtAddrReq, in, NCH: level read request per channel.
- oLdata, out, NCH*ADDR_LENTH: read result per channel; zero when the matching oLdataVld bit is low.
- oLdataVld, out, NCH: one-cycle result strobe per channel.
- iDropAddr, in, ADDR_LENTH: drop-channel read address.
- iDropAddrVld, in, 1: drop-channel read request (single-cycle).
- oDropData, out, ADDR_LENTH: drop result; zero when not valid.
- oDropDataVld, out, 1: drop result strobe.

## Operation
- Memory: one write port and one read port. Reads have 1-cycle latency. Contents are not reset.
- Write FIFOs:
  - Each channel has a show-ahead FIFO holding {data, addr}.
  - A push into a full FIFO, without a same-cycle pop, is discarded and sets oWrOvf[k].
  - oWrOvf bits clear only on reset.
- Write arbiter:
  - Each cycle, grant one non-empty FIFO in round-robin order starting at wPtr.
  - The granted FIFO pops, and its entry is written to memory on that edge.
  - After a grant to channel k, wPtr becomes (k+1) mod NCH. With no grant, wPtr holds.
- Read arbiter:
  - iDropAddrVld has absolute priority and uses the read port that cycle.
  - Otherwise, grant one eligible channel in round-robin order from rPtr, then set rPtr to (k+1) mod NCH.
  - A drop grant leaves rPtr unchanged.
  - Channel k is eligible when iLNxtAddrReq[k]=1 and oLdataVld[k]=0.
  - Each grant produces exactly one result.
  - A requester must deassert iLNxtAddrReq in the cycle it sees oLdataVld, or it is granted again.
- Forwarding: if a read is granted in the same cycle as a memory write to the same address, the result is the write data, not the old memory content.
- Result routing: a 1-cycle registered tag records the granted read source (channel index, drop, or none). The tag steers the read data onto exactly one output strobe.

## Timing
- Reset values: oLdata=0, oLdataVld=0, oDropData=0, oDropDataVld=0, oWrOvf=0. wPtr=0, rPtr=0, FIFOs empty, tag=none.
- Write path latency:
  - Push at edge t makes the entry visible at t+1.
  - The earliest memory write is at the end of cycle t+1.
  - With all NCH channels pushing every cycle, each is serviced once per NCH cycles; the FIFO absorbs the burst.
- Read latency: a grant in cycle t gives oLdataVld (or oDropDataVld) high in cycle t+1 for exactly one cycle.
- A held request is served at most every 2 cycles. With multiple requesters, the read port can be granted every cycle.
- Simultaneous events:
  - Drop plus channel requests: drop wins, and the channels wait with no loss.
  - Push and pop on the same FIFO when full: both happen, with no overflow.
- Pointer wrap: from NCH-1, the next search starts at 0.
- Reset mid-operation: FIFO entries and pending results are discarded, and all outputs go to 0 asynchronously.

## Test plan
- Write/read basic: ch0 pushes addr 0x010 data 0x055; after 3 cycles ch2 requests 0x010 → oLdataVld[2] pulses one cycle later with oLdata ch2 = 0x055; other bits are 0.
- Write round-robin: all 4 channels push distinct entries every cycle for 2 cycles (WFIFO_DEPTH=2) → memory write order is ch0, ch1, ch2, ch3, ch0, …; no oWrOvf; all 8 read back correctly. A third push burst on ch3 while full sets oWrOvf[3]=1 and loses only that entry.
- Read round-robin with drop: ch0..ch3 requests held, iDropAddrVld in the 2nd cycle → grant order ch0, drop, ch1, ch2, ch3, then ch0 again; oDropDataVld appears exactly one cycle after the drop cycle.
- Forwarding: address 0x3FF holds 0x001; a write of 0x7AB to 0x3FF and a ch1 read of 0x3FF are granted in the same cycle → oLdata ch1 = 0x7AB.
- Reset mid-stream: assert iRst_n=0 with 2 FIFO entries pending and a read outstanding → all outputs are 0 immediately; after release, no stale write occurs and no stale oLdataVld appears.
- Parameter sweep: NCH=2/8 and ADDR_LENTH=10 with random push/request traffic checked against a reference model: every grant returns exactly one result and the last written value per address (forwarding included).
